psum_accumulator: RTL and testbench

//  Consumes the 32-bit signed partial sums from the 3-tap PE and accumulates them over one

---
 rtl/conv_acc_pkg.sv | 29 ++
 rtl/requant_sat.sv | 42 ++++
 rtl/psum_accumulator.sv | 113 +++++++++++
 tb/tb_psum_accumulator.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_pkg.sv
// Shared widths and limits for the convolution accumulate / requantise path.
// Used by the PE array, this accumulator and the OFM write buffer.
package conv_acc_pkg;

   localparam int PSUM_W  = 32;
   localparam int ACC_W   = 40;
   localparam int OUT_W   = 8;
   localparam int SHIFT_W = 5;
   localparam int BIAS_W  = 32;
   localparam int COUNT_W = 16;

   localparam int OUT_MAX = 127;
   localparam int OUT_MIN = -128;

   typedef logic signed [PSUM_W-1:0] psum_t;
   typedef logic signed [ACC_W-1:0]  acc_t;
   typedef logic signed [OUT_W-1:0]  act_t;

   // Sign-extend a PE partial sum to accumulator width.
   function automatic acc_t sext_psum(input psum_t p);
      return acc_t'(p);
   endfunction

   // Signed add overflow: operands agree in sign but the result does not.
   function automatic logic add_overflows(input acc_t a, input acc_t b, input acc_t s);
      return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
   endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantisation: bias add, round-half-up arithmetic right
// shift, optional ReLU and saturation to the signed output range.
module requant_sat
   import conv_acc_pkg::*;
(
   input  logic signed [ACC_W-1:0]  acc_in,
   input  logic signed [BIAS_W-1:0] bias,
   input  logic [SHIFT_W-1:0]       shift,
   input  logic                     relu_en,
   output logic signed [OUT_W-1:0]  act_out
);

   localparam int VW = ACC_W + 1;
   localparam logic signed [VW-1:0] SAT_HI = VW'(OUT_MAX);
   localparam logic signed [VW-1:0] SAT_LO = VW'(OUT_MIN);

   logic signed [VW-1:0] biased;
   logic signed [VW-1:0] rounded;
   logic signed [VW-1:0] shifted;
   logic signed [VW-1:0] rectified;

   // One extra bit keeps acc + bias exact; the half-LSB rounding term
   // (at most 2^30) still fits because |acc + bias| stays below 2^40.
   always_comb begin
      biased    = {acc_in[ACC_W-1], acc_in} + {{(VW-BIAS_W){bias[BIAS_W-1]}}, bias};
      rounded   = biased;
      shifted   = biased;
      if (shift != '0) begin
         rounded = biased + (VW'(1) << (shift - SHIFT_W'(1)));
         shifted = rounded >>> shift;
      end
      rectified = (relu_en && shifted < 0) ? '0 : shifted;
      if (rectified > SAT_HI) begin
         act_out = OUT_W'(OUT_MAX);
      end else if (rectified < SAT_LO) begin
         act_out = OUT_W'(OUT_MIN);
      end else begin
         act_out = rectified[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates PE partial sums over one output pixel's group, then
// requantises the total through a two-stage pipeline into one OFM byte.
// The whole path stalls together when the output byte is not taken.
module psum_accumulator
   import conv_acc_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [PSUM_W-1:0] psum_in,
   input  logic                     psum_valid,
   input  logic                     psum_first,
   input  logic                     psum_last,
   output logic                     in_ready,
   input  logic signed [BIAS_W-1:0] bias,
   input  logic [SHIFT_W-1:0]       shift,
   input  logic                     relu_en,
   output logic signed [OUT_W-1:0]  ofm_out,
   output logic                     ofm_valid,
   input  logic                     ofm_ready,
   output logic                     acc_overflow,
   output logic [COUNT_W-1:0]       ofm_count
);

   logic en;
   logic accept;
   acc_t acc;
   acc_t base;
   acc_t psum_ext;
   acc_t sum;
   logic sum_ovf;

   logic                     a_valid;
   acc_t                     a_sum;
   logic signed [BIAS_W-1:0] a_bias;
   logic [SHIFT_W-1:0]       a_shift;
   logic                     a_relu;

   act_t req_out;

   // The pipeline may only move when the output register is free or being emptied.
   always_comb begin
      en       = !ofm_valid || ofm_ready;
      in_ready = en;
      accept   = psum_valid && en;
      base     = psum_first ? '0 : acc;
      psum_ext = sext_psum(psum_in);
      sum      = base + psum_ext;
      sum_ovf  = add_overflows(base, psum_ext, sum);
   end

   // Running accumulator; cleared on the last beat so the next group starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc          <= '0;
         acc_overflow <= 1'b0;
      end else if (accept) begin
         acc <= psum_last ? '0 : sum;
         if (sum_ovf) begin
            acc_overflow <= 1'b1;
         end
      end
   end

   // Stage A captures the finished group total and its requant settings.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_valid <= 1'b0;
         a_sum   <= '0;
         a_bias  <= '0;
         a_shift <= '0;
         a_relu  <= 1'b0;
      end else if (en) begin
         a_valid <= accept && psum_last;
         if (accept && psum_last) begin
            a_sum   <= sum;
            a_bias  <= bias;
            a_shift <= shift;
            a_relu  <= relu_en;
         end
      end
   end

   requant_sat u_requant (
      .acc_in  (a_sum),
      .bias    (a_bias),
      .shift   (a_shift),
      .relu_en (a_relu),
      .act_out (req_out)
   );

   // Stage B registers the requantised byte; an empty stage A drops valid once taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ofm_out   <= '0;
         ofm_valid <= 1'b0;
      end else if (en) begin
         ofm_valid <= a_valid;
         if (a_valid) begin
            ofm_out <= req_out;
         end
      end
   end

   // Counts completed handoffs; wraps naturally at the counter width.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ofm_count <= '0;
      end else if (ofm_valid && ofm_ready) begin
         ofm_count <= ofm_count + COUNT_W'(1);
      end
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: stimulus tasks push reference
// results into a queue, an independent monitor pops them on each handoff.
module tb_psum_accumulator;
   import conv_acc_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic signed [PSUM_W-1:0] psum_in;
   logic                     psum_valid;
   logic                     psum_first;
   logic                     psum_last;
   logic                     in_ready;
   logic signed [BIAS_W-1:0] bias;
   logic [SHIFT_W-1:0]       shift;
   logic                     relu_en;
   logic signed [OUT_W-1:0]  ofm_out;
   logic                     ofm_valid;
   logic                     ofm_ready;
   logic                     acc_overflow;
   logic [COUNT_W-1:0]       ofm_count;

   int     n_vec = 0;
   int     n_miscompare = 0;
   longint exp_q[$];
   longint acc_m = 0;
   bit     ovf_m = 0;
   int     ready_mode = 0;
   int     exp_count = 0;

   psum_accumulator dut (
      .clk          (clk),
      .rst          (rst),
      .psum_in      (psum_in),
      .psum_valid   (psum_valid),
      .psum_first   (psum_first),
      .psum_last    (psum_last),
      .in_ready     (in_ready),
      .bias         (bias),
      .shift        (shift),
      .relu_en      (relu_en),
      .ofm_out      (ofm_out),
      .ofm_valid    (ofm_valid),
      .ofm_ready    (ofm_ready),
      .acc_overflow (acc_overflow),
      .ofm_count    (ofm_count)
   );

   always #5 clk = ~clk;

   // Reference: wrap an exact sum into a 40-bit two's complement range.
   function automatic longint wrap40(input longint s);
      longint t;
      t = s;
      while (t >= (longint'(1) <<< 39)) t = t - (longint'(1) <<< 40);
      while (t < -(longint'(1) <<< 39)) t = t + (longint'(1) <<< 40);
      return t;
   endfunction

   // Reference: floor((v + d/2) / d), ReLU, clamp to int8.
   function automatic longint requant_model(input longint acc, input longint b, input int sh, input bit relu);
      longint v, d, num, r;
      v = acc + b;
      if (sh == 0) begin
         r = v;
      end else begin
         d   = longint'(1) <<< sh;
         num = v + d / 2;
         r   = num / d;
         if ((num % d) != 0 && num < 0) r = r - 1;
      end
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic signed [63:0] actual, input logic signed [63:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_miscompare++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drives one beat until accepted, then updates the reference model.
   task automatic applyStimulus(input int psum, input bit first, input bit last,
                                input int b, input int sh, input bit relu);
      int     waited;
      bit     took;
      longint s, w;
      waited = 0;
      took   = 0;
      psum_in    = psum;
      psum_valid = 1'b1;
      psum_first = first;
      psum_last  = last;
      bias       = last ? b : 32'($urandom);
      shift      = last ? SHIFT_W'(sh) : SHIFT_W'($urandom);
      relu_en    = last ? relu : 1'($urandom);
      while (!took && waited < 2000) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      psum_valid = 1'b0;
      psum_first = 1'b0;
      psum_last  = 1'b0;
      if (!took) begin
         n_vec++;
         n_miscompare++;
         $display("[TB] FAIL beat_accept_timeout: got no in_ready, expected acceptance within 2000 cycles");
      end else begin
         s = (first ? 64'sd0 : acc_m) + longint'(psum);
         w = wrap40(s);
         if (w != s) ovf_m = 1;
         if (last) begin
            exp_q.push_back(requant_model(w, longint'(b), sh, relu));
            acc_m = 0;
         end else begin
            acc_m = w;
         end
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      psum_valid = 1'b0;
      psum_first = 1'b0;
      psum_last  = 1'b0;
      exp_q.delete();
      acc_m = 0;
      ovf_m = 0;
      #1;
      checkOutput("rst_ofm_out", ofm_out, 0);
      checkOutput("rst_ofm_valid", ofm_valid, 0);
      checkOutput("rst_overflow", acc_overflow, 0);
      checkOutput("rst_ofm_count", ofm_count, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ofm_valid) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      if (n >= 1000) begin
         n_vec++;
         n_miscompare++;
         $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", exp_q.size());
      end
   endtask

   // Expects the result of the beat just accepted exactly two edges later.
   task automatic expectAfterLast(input string name, input longint val);
      @(negedge clk);
      checkOutput({name, "_early"}, ofm_valid, 0);
      @(negedge clk);
      checkOutput({name, "_valid"}, ofm_valid, 1);
      checkOutput(name, ofm_out, val);
      @(posedge clk);
      #1;
   endtask

   // Downstream ready generator: always, random, or held low.
   initial begin
      ofm_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       ofm_ready = 1'b1;
            1:       ofm_ready = 1'($urandom);
            default: ofm_ready = 1'b0;
         endcase
      end
   end

   // Monitor: scoreboard pops on handoff, and held outputs must stay stable.
   initial begin
      bit     hold;
      longint prev;
      hold = 0;
      prev = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_count = 0;
            hold = 0;
         end else begin
            if (hold) begin
               checkOutput("hold_valid", ofm_valid, 1);
               checkOutput("hold_data", ofm_out, prev);
            end
            if (ofm_valid && ofm_ready) begin
               checkOutput("ofm_count", ofm_count, exp_count);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miscompare++;
                  $display("[TB] FAIL unexpected_output: got %0d, expected no output", ofm_out);
               end else begin
                  checkOutput("ofm_out", ofm_out, exp_q.pop_front());
               end
               exp_count = (exp_count + 1) % 65536;
            end
            hold = ofm_valid && !ofm_ready;
            prev = longint'(ofm_out);
         end
      end
   end

   initial begin
      int len, cnt0, p, b, sh;
      rst = 1'b1;
      psum_in = '0;
      psum_valid = 1'b0;
      psum_first = 1'b0;
      psum_last = 1'b0;
      bias = '0;
      shift = '0;
      relu_en = 1'b0;
      @(posedge clk);
      #1;
      doReset();
      checkOutput("idle_in_ready", in_ready, 1);

      // Saturating three-beat group with latency check
      applyStimulus(100, 1, 0, 0, 0, 0);
      applyStimulus(200, 0, 0, 0, 0, 0);
      applyStimulus(-50, 0, 1, 0, 0, 0);
      expectAfterLast("sat_250", 127);

      // Bias and rounding shift
      applyStimulus(1000, 1, 0, 0, 0, 0);
      applyStimulus(24, 0, 1, -24, 3, 0);
      expectAfterLast("shift3", 125);
      applyStimulus(1000, 1, 0, 0, 0, 0);
      applyStimulus(24, 0, 1, -24, 4, 0);
      expectAfterLast("shift4_round", 63);

      // One-beat groups: ReLU and negative saturation
      applyStimulus(-300, 1, 1, 0, 0, 1);
      expectAfterLast("relu_neg", 0);
      applyStimulus(-300, 1, 1, 0, 1, 0);
      expectAfterLast("neg_sat", -128);

      // Backpressure: result pending while downstream refuses
      waitDrain();
      cnt0 = exp_count;
      ready_mode = 2;
      applyStimulus(42, 1, 1, 0, 0, 0);
      applyStimulus(3, 1, 0, 0, 0, 0);
      fork
         applyStimulus(4, 0, 1, 0, 0, 0);
         begin
            repeat (5) begin
               @(negedge clk);
               checkOutput("stall_in_ready", in_ready, 0);
               checkOutput("stall_ofm_out", ofm_out, 42);
            end
            ready_mode = 0;
         end
      join
      waitDrain();
      checkOutput("stall_count", ofm_count, (cnt0 + 2) % 65536);

      // Back-to-back one-beat groups
      cnt0 = exp_count;
      applyStimulus(5, 1, 1, 0, 0, 0);
      applyStimulus(6, 1, 1, 0, 0, 0);
      applyStimulus(7, 1, 1, 0, 0, 0);
      @(negedge clk);
      checkOutput("b2b_valid_6", ofm_valid, 1);
      checkOutput("b2b_out_6", ofm_out, 6);
      @(negedge clk);
      checkOutput("b2b_valid_7", ofm_valid, 1);
      checkOutput("b2b_out_7", ofm_out, 7);
      @(negedge clk);
      checkOutput("b2b_idle", ofm_valid, 0);
      @(posedge clk);
      #1;
      checkOutput("b2b_count", ofm_count, (cnt0 + 3) % 65536);

      // Randomised groups with random backpressure and input gaps
      ready_mode = 1;
      for (int g = 0; g < 60; g++) begin
         len = int'($urandom_range(1, 6));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) p = int'($urandom);
            else p = int'($urandom_range(0, 4000)) - 2000;
            b  = int'($urandom_range(0, 2000)) - 1000;
            sh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 8));
            applyStimulus(p, (k == 0) ? ($urandom_range(0, 3) != 0) : 1'b0, k == len - 1,
                          b, sh, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
               @(posedge clk);
               #1;
            end
         end
      end
      ready_mode = 0;
      waitDrain();
      checkOutput("rand_no_overflow", acc_overflow, ovf_m);

      // Accumulator overflow is sticky; reset mid-group recovers cleanly
      applyStimulus(2147483647, 1, 0, 0, 0, 0);
      for (int k = 1; k < 300; k++) applyStimulus(2147483647, 0, 0, 0, 0, 0);
      checkOutput("ovf_set", acc_overflow, 1);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("ovf_sticky", acc_overflow, 1);
      doReset();
      applyStimulus(10, 1, 0, 0, 0, 0);
      applyStimulus(20, 0, 1, 0, 0, 0);
      expectAfterLast("post_rst", 30);
      waitDrain();
      checkOutput("post_rst_count", ofm_count, 1);
      checkOutput("post_rst_ovf", acc_overflow, 0);

      checkOutput("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
      $finish;
   end

endmodule
